// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch bridge: FSM state encoding,
// the suppressed-fetch instruction, the boot PC and the kseg translation constants.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

  // Instruction handed to the pipeline when an address error suppresses the fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Boot PC of the core (kseg1 ROM).
  localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;

  // kseg0/kseg1 are selected by VA[31:30]==2'b10; the physical address keeps VA[28:0].
  localparam logic [1:0]  KSEG_SEL  = 2'b10;
  localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;

endpackage

// File: rtl/inst_addr_map.sv
// Combinational kseg0/kseg1 -> physical translation of the fetch address.
// Only instantiated when INST_FETCH_KSEG_MAP_EN is defined.
module inst_addr_map
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Strip the segment bits of unmapped kernel segments; everything else passes through.
  always_comb begin
    addr_o = addr_i;
    if (addr_i[ADDR_W-1 -: 2] == KSEG_SEL) begin
      addr_o = addr_i & ADDR_W'(KSEG_MASK);
    end
  end

endmodule

// File: rtl/inst_fetch_bridge.sv
// Fetch-stage bridge between the PC register and an SRAM-like instruction bus.
// One bus transaction per PC, result held until the pipeline consumes it.
// Optional build macro: INST_FETCH_KSEG_MAP_EN (kseg0/kseg1 address translation
// applied when the PC is latched in IDLE).
//
// Bus handshake: inst_req is held with a stable inst_addr until a cycle in which
// inst_addr_ok is high (the address is accepted on that clock edge); the read data
// is then taken on the first later edge with inst_data_ok high. Only one transaction
// is ever outstanding, and inst_data_ok is looked at only while one is.
// Pipeline side: instr_valid means instr/instr_adel belong to the current pcf; the
// result is consumed on an edge with en (or discarded with flush) high.
module inst_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(mips_fetch_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcf,
  input  logic              pcf_adel,
  input  logic              en,
  input  logic              flush,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_data_ok,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_adel,
  output logic              stall_f
);

  import mips_fetch_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              adel_q, adel_d;
  // A flush arrived while the address phase could not be withdrawn.
  logic              flush_seen_q, flush_seen_d;
  logic [ADDR_W-1:0] mapped_addr;

`ifdef INST_FETCH_KSEG_MAP_EN
  inst_addr_map #(
    .ADDR_W (ADDR_W)
  ) u_addr_map (
    .addr_i (pcf),
    .addr_o (mapped_addr)
  );
`else
  assign mapped_addr = pcf;
`endif

  // Next-state and datapath-update logic of the fetch FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    adel_d       = adel_q;
    flush_seen_d = flush_seen_q;

    case (state_q)
      ST_IDLE: begin
        // A redirect this cycle means pcf is not yet the new target: sample again.
        if (!flush) begin
          if (pcf_adel) begin
            instr_d = NOP_INSTR;
            adel_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = mapped_addr;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        if (flush) begin
          flush_seen_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = (flush_seen_q || flush) ? ST_DROP : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (inst_data_ok) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            instr_d = inst_rdata;
            adel_d  = 1'b0;
            state_d = ST_DONE;
          end
        end else if (flush) begin
          state_d = ST_DROP;
        end
      end

      ST_DROP: begin
        // The bus still owes us the data of the abandoned fetch; swallow it.
        if (inst_data_ok) begin
          flush_seen_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (en || flush) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      instr_q      <= '0;
      adel_q       <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      adel_q       <= adel_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  assign inst_req    = (state_q == ST_REQ);
  assign inst_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_DONE);
  assign instr_adel  = adel_q;
  assign stall_f     = ~instr_valid;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed vector table, hand-written flush/reset
// sequences, then randomized pipeline/bus traffic against a memory-image model.
module tb_inst_fetch_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcf;
  logic        pcf_adel;
  logic        en;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_adel;
  logic        stall_f;

  int total = 0;
  int bad   = 0;

  // Scoreboard of instructions expected from directed fetches.
  logic [31:0] exp_q[$];
  // Per-transaction bus behaviour; empty queues mean random latency / memory data.
  int          a_q[$];
  int          d_q[$];
  logic [31:0] rd_q[$];
  logic        bus_off = 1'b0;

  inst_fetch_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .pcf          (pcf),
    .pcf_adel     (pcf_adel),
    .en           (en),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_adel   (instr_adel),
    .stall_f      (stall_f)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference rules ----------------
  function automatic logic [31:0] exp_map(input logic [31:0] pc);
`ifdef INST_FETCH_KSEG_MAP_EN
    if (pc[31:30] == 2'b10) return {3'b000, pc[28:0]};
`endif
    return pc;
  endfunction

  // Contents of instruction memory at a physical address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5bd1_e995;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom;
    if ($urandom_range(0, 9) == 0) p[1:0] = 2'($urandom_range(1, 3));
    else p[1:0] = 2'b00;
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin : responder
    int          req_cnt;
    int          cur_a;
    int          d_cnt;
    logic        in_req;
    logic        pending;
    logic [31:0] req_addr;
    req_cnt = 0; cur_a = 0; d_cnt = 0; in_req = 1'b0; pending = 1'b0; req_addr = '0;
    forever begin
      @(negedge clk);
      if (rst || bus_off) begin
        in_req  = 1'b0;
        pending = 1'b0;
        if (!bus_off) begin
          inst_addr_ok = 1'b0;
          inst_data_ok = 1'b0;
        end
      end else begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        if (pending) begin
          check_b("one_outstanding", inst_req, 1'b0);
          d_cnt--;
          if (d_cnt <= 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = (rd_q.size() > 0) ? rd_q.pop_front() : mem_word(req_addr);
            pending      = 1'b0;
          end
        end else if (inst_req) begin
          if (!in_req) begin
            in_req   = 1'b1;
            req_addr = inst_addr;
            req_cnt  = 0;
            cur_a    = (a_q.size() > 0) ? a_q.pop_front() : int'($urandom_range(0, 3));
          end else begin
            check("addr_stable", inst_addr, req_addr);
          end
          if (req_cnt >= cur_a) begin
            inst_addr_ok = 1'b1;
            in_req       = 1'b0;
            pending      = 1'b1;
            d_cnt        = (d_q.size() > 0) ? d_q.pop_front() : int'($urandom_range(1, 3));
          end else begin
            req_cnt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait (bounded) for instr_valid; report negedges taken, request cycles seen
  // and the first requested address.
  task automatic await_valid(input int budget, output int lat, output int reqs,
                             output logic [31:0] first_addr);
    logic seen;
    seen = 1'b0;
    lat = 0;
    reqs = 0;
    first_addr = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      lat++;
      if (inst_req) begin
        reqs++;
        if (!seen) begin
          first_addr = inst_addr;
          seen = 1'b1;
        end
      end
      if (instr_valid) break;
    end
    check_b("await_valid", instr_valid, 1'b1);
  endtask

  // Consume the held instruction; leaves the bench on the following IDLE negedge.
  task automatic consume(input logic with_flush);
    en = 1'b1;
    flush = with_flush;
    @(negedge clk);
    en = 1'b0;
    flush = 1'b0;
    check_b("consumed_valid", instr_valid, 1'b0);
    check_b("consumed_stall", stall_f, 1'b1);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        adel;
    int          a_lat;
    int          d_lat;
    logic [31:0] rdata;
    int          hold;
    logic [31:0] exp_instr;
    logic        exp_adel;
    int          exp_lat;
    int          exp_req;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          reqs;
    logic [31:0] addr;
    logic [31:0] exp;
    pcf = v.pc;
    pcf_adel = v.adel;
    if (!v.adel) begin
      a_q.push_back(v.a_lat);
      d_q.push_back(v.d_lat);
      rd_q.push_back(v.rdata);
    end
    exp_q.push_back(v.exp_instr);
    await_valid(20, lat, reqs, addr);
    exp = exp_q.pop_front();
    check($sformatf("vec%0d_lat", idx), lat, v.exp_lat);
    check($sformatf("vec%0d_req_cycles", idx), reqs, v.exp_req);
    if (!v.adel) check($sformatf("vec%0d_addr", idx), addr, exp_map(v.pc));
    check($sformatf("vec%0d_instr", idx), instr, exp);
    check_b($sformatf("vec%0d_adel", idx), instr_adel, v.exp_adel);
    check_b($sformatf("vec%0d_stall", idx), stall_f, 1'b0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check_b($sformatf("vec%0d_hold_valid", idx), instr_valid, 1'b1);
      check($sformatf("vec%0d_hold_instr", idx), instr, exp);
      check_b($sformatf("vec%0d_hold_req", idx), inst_req, 1'b0);
    end
    consume(1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t        vecs[7];
    int          lat;
    int          reqs;
    logic [31:0] addr;
    logic [31:0] held;
    logic        held_ok;
    int          since_valid;
    int          r;

    vecs[0] = '{32'hbfc0_0000, 1'b0, 0, 1, 32'h2408_0001, 0, 32'h2408_0001, 1'b0, 3, 1};
    vecs[1] = '{32'hbfc0_0002, 1'b1, 0, 0, 32'h0,         0, 32'h0000_0000, 1'b1, 1, 0};
    vecs[2] = '{32'hbfc0_0004, 1'b0, 2, 3, 32'h8fa4_0010, 5, 32'h8fa4_0010, 1'b0, 7, 3};
    vecs[3] = '{32'h0040_0000, 1'b0, 1, 1, 32'h3c1d_1001, 0, 32'h3c1d_1001, 1'b0, 4, 2};
    vecs[4] = '{32'h9fc0_0010, 1'b0, 0, 2, 32'h27bd_fff0, 2, 32'h27bd_fff0, 1'b0, 4, 1};
    vecs[5] = '{32'h7fff_fffc, 1'b0, 3, 1, 32'hffff_ffff, 1, 32'hffff_ffff, 1'b0, 6, 4};
    vecs[6] = '{32'hbfc0_0001, 1'b1, 0, 0, 32'h0,         3, 32'h0000_0000, 1'b1, 1, 0};

    // reset
    pcf = 32'hbfc0_0000; pcf_adel = 1'b0; en = 1'b0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    repeat (3) @(negedge clk);
    check_b("rst_req", inst_req, 1'b0);
    check("rst_addr", inst_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check_b("rst_valid", instr_valid, 1'b0);
    check_b("rst_adel", instr_adel, 1'b0);
    check_b("rst_stall", stall_f, 1'b1);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // flush in WAIT: the late data must never be presented
    pcf = 32'hbfc0_0200; pcf_adel = 1'b0;
    a_q.push_back(0); d_q.push_back(3); rd_q.push_back(32'hdead_beef);
    @(negedge clk);
    check_b("fw_req", inst_req, 1'b1);
    @(negedge clk);
    check_b("fw_wait_req", inst_req, 1'b0);
    flush = 1'b1; pcf = 32'hbfc0_0100;
    a_q.push_back(0); d_q.push_back(1); rd_q.push_back(32'h1111_2222);
    @(negedge clk);
    flush = 1'b0;
    await_valid(20, lat, reqs, addr);
    check("fw_lat", lat, 5);
    check("fw_addr", addr, exp_map(32'hbfc0_0100));
    check("fw_instr", instr, 32'h1111_2222);
    check_b("fw_adel", instr_adel, 1'b0);
    pcf = 32'hbfc0_0600;
    consume(1'b1);

    // flush in REQ while addr_ok is held off
    pcf = 32'hbfc0_0300;
    a_q.push_back(3); d_q.push_back(1); rd_q.push_back(32'hcafe_f00d);
    @(negedge clk);
    check_b("fr_req", inst_req, 1'b1);
    flush = 1'b1; pcf = 32'hbfc0_0400;
    a_q.push_back(0); d_q.push_back(1); rd_q.push_back(32'h0bad_c0de);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flush = 1'b0;
      check_b("fr_req_held", inst_req, 1'b1);
      check("fr_addr_held", inst_addr, exp_map(32'hbfc0_0300));
    end
    await_valid(20, lat, reqs, addr);
    check("fr_lat", lat, 5);
    check("fr_addr", addr, exp_map(32'hbfc0_0400));
    check("fr_instr", instr, 32'h0bad_c0de);
    consume(1'b0);

    // asynchronous reset in WAIT, then a stray data_ok while IDLE
    pcf = 32'hbfc0_0500;
    a_q.push_back(0); d_q.push_back(3);
    @(negedge clk);
    @(negedge clk);
    check_b("ar_wait_req", inst_req, 1'b0);
    #2;
    rst = 1'b1; bus_off = 1'b1;
    #1;
    check_b("ar_req", inst_req, 1'b0);
    check_b("ar_valid", instr_valid, 1'b0);
    check_b("ar_stall", stall_f, 1'b1);
    check("ar_instr", instr, 32'h0);
    check("ar_addr", inst_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; pcf = 32'hbfc0_0600; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
    @(negedge clk);
    inst_data_ok = 1'b0;
    check_b("ar_new_req", inst_req, 1'b1);
    check("ar_new_addr", inst_addr, exp_map(32'hbfc0_0600));
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    check_b("ar_no_early_valid", instr_valid, 1'b0);
    inst_data_ok = 1'b1; inst_rdata = 32'h1357_9bdf;
    @(negedge clk);
    inst_data_ok = 1'b0;
    check_b("ar_valid_after", instr_valid, 1'b1);
    check("ar_instr_after", instr, 32'h1357_9bdf);
    bus_off = 1'b0;
    consume(1'b0);

    // randomized traffic against the memory-image model
    held = '0; held_ok = 1'b0; since_valid = 0;
    pcf = rand_pc(); pcf_adel = |pcf[1:0];
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      en = 1'b0; flush = 1'b0;
      check_b("rnd_stall", stall_f, ~instr_valid);
      if (instr_valid) begin
        since_valid = 0;
        if (!held_ok) begin
          check("rnd_instr", instr, (|pcf[1:0]) ? 32'h0 : mem_word(exp_map(pcf)));
          check_b("rnd_adel", instr_adel, |pcf[1:0]);
          held = instr;
          held_ok = 1'b1;
        end else begin
          check("rnd_hold_instr", instr, held);
          check_b("rnd_hold_req", inst_req, 1'b0);
        end
      end else begin
        since_valid++;
        if (since_valid > 40) begin
          check("rnd_progress", since_valid, 0);
          since_valid = 0;
        end
      end
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        flush = 1'b1;
        pcf = rand_pc() ^ 32'h0000_1000;
        pcf_adel = |pcf[1:0];
        held_ok = 1'b0;
        since_valid = 0;
      end else if (instr_valid && r < 55) begin
        en = 1'b1;
        pcf = (|pcf[1:0] || r < 15) ? rand_pc() : pcf + 32'd4;
        pcf_adel = |pcf[1:0];
        held_ok = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends with its summary line.
  initial begin : watchdog
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Consumer end of the fetch-address interface.
- Takes the fetch-stage PC (pcf) and its alignment-error flag from the PC register.
- Issues one transaction per PC on the SRAM-like instruction bus: req/addr_ok address phase, then data_ok data phase.
- Holds the returned instruction until the pipeline consumes it, and drives stall_f back to the PC register's enable.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, instruction width.
- NOP_INSTR, 32'h0000_0000, instruction presented when the fetch is suppressed by an address error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- pcf  in  ADDR_W  fetch-stage PC.
- pcf_adel  in  1  pcf misaligned (pcf[1:0]!=0).
- en  in  1  fetch stage advances this cycle; consumes the held instruction.
- flush  in  1  pipeline redirect; abandon the current fetch.
- inst_req  out  1  bus request, address phase.
- inst_addr  out  ADDR_W  bus address.
- inst_addr_ok  in  1  address accepted.
- inst_rdata  in  DATA_W  read data.
- inst_data_ok  in  1  read data valid.
- instr  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr holds data for the current pcf.
- instr_adel  out  1  held result is an address error.
- stall_f  out  1  equals ~instr_valid; gates PC en upstream.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous, active-high.
  - State goes to IDLE.
  - inst_req=0, inst_addr=0, instr=0, instr_valid=0, instr_adel=0, stall_f=1.
- States: IDLE, REQ, WAIT, DONE, DROP.
- IDLE:
  - If pcf_adel: go to DONE with instr=NOP_INSTR and instr_adel=1. No bus transaction is issued.
  - Else: latch inst_addr from pcf and go to REQ.
  - If flush: stay in IDLE so pcf is re-sampled next cycle.
- REQ:
  - inst_req=1. inst_addr stays stable until addr_ok.
  - On inst_addr_ok: go to WAIT, or to DROP if a flush was seen during REQ (sticky flag, cleared on leaving DROP).
  - The request is never withdrawn before addr_ok.
- WAIT:
  - inst_req=0.
  - On inst_data_ok: latch instr=inst_rdata, set instr_adel=0, go to DONE.
  - If flush without data_ok: go to DROP.
  - If flush and data_ok in the same cycle: discard the data and go to IDLE.
- DROP:
  - Wait for inst_data_ok, discard the data, go to IDLE.
  - Further flushes have no effect.
- DONE:
  - instr_valid=1.
  - If en or flush: clear instr_valid and go to IDLE. The next PC is fetched starting the next cycle.
  - If both en and flush: flush semantics apply (same transition).
- inst_data_ok is sampled only in WAIT and DROP; it is ignored elsewhere. The bus guarantees data_ok arrives at least one cycle after addr_ok.
- Latency: IDLE to instr_valid is minimum 3 cycles (IDLE, REQ with addr_ok, WAIT with data_ok). Throughput is one instruction per 4 cycles minimum, including DONE.
- At most one transaction is outstanding.
- Reset mid-transaction returns to IDLE immediately. A late data_ok after reset is ignored because IDLE does not sample it.

Optional Feature:
- Macro: INST_FETCH_KSEG_MAP_EN.
- Defined: when pcf[31:30]==2'b10 (kseg0/kseg1), inst_addr = {3'b000, pcf[28:0]}. Other addresses pass through unchanged.
- Undefined: inst_addr = pcf unmodified.
- Mapping is applied at the IDLE latch only.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - state enum (IDLE, REQ, WAIT, DONE, DROP);
  - NOP_INSTR;
  - RESET_PC 32'hbfc0_0000;
  - KSEG_MASK constant.
- Sub-module inst_addr_map holds the combinational kseg translation, instantiated under INST_FETCH_KSEG_MAP_EN.
- FSM and data latch stay in the top module.

Test Plan:
- Basic fetch:
  - Stimulus: release reset with pcf=32'hbfc00000; addr_ok in the first REQ cycle; data_ok one cycle later with rdata=32'h2408_0001.
  - Required: inst_req high for exactly 1 cycle with inst_addr=bfc00000 (1fc00000 with the macro defined); instr_valid=1 on cycle 3; stall_f=0 while in DONE.
- Address error:
  - Stimulus: pcf=32'hbfc00002, pcf_adel=1.
  - Required: inst_req never asserts; instr=0 and instr_adel=1 in DONE; en=1 returns the block to IDLE.
- Flush in WAIT:
  - Stimulus: flush pulse in WAIT; data_ok 2 cycles later with 32'hdeadbeef; pcf then 32'hbfc00100.
  - Required: deadbeef is never presented; next inst_addr=bfc00100.
- Flush in REQ:
  - Stimulus: flush with addr_ok held low 3 cycles.
  - Required: inst_req stays high with a stable address until addr_ok; the block then goes to DROP and discards the data.
- Stall hold:
  - Stimulus: in DONE, hold en=0 for 5 cycles.
  - Required: instr and instr_valid remain stable; no new inst_req.
- Async reset mid-transaction:
  - Stimulus: assert rst in WAIT.
  - Required: inst_req and instr_valid go to 0 immediately; a data_ok arriving after reset release is ignored.
